// File: rtl/score_seg_scan.sv
// Score display: binary score -> BCD (double dabble) -> multiplexed 7-seg.
// Optional leading-zero blanking when SCORE_SEG_SCAN_BLANK_EN is defined.
//
// Ports:
//   clk_100mhz  in   sole clock, rising edge
//   RSTN        in   synchronous active-low reset
//   score       in   [SCORE_W-1:0] unsigned binary score
//   score_valid in   one-cycle capture request
//   busy        out  conversion in progress
//   overflow    out  shown value exceeds 10^DIGITS-1
//   segment     out  [7:0] active-low {dp,g,f,e,d,c,b,a}
//   AN          out  [DIGITS-1:0] active-low one-hot digit enable
module score_seg_scan #(
  parameter int SCORE_W     = 32,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic               clk_100mhz,
  input  logic               RSTN,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_valid,
  output logic               busy,
  output logic               overflow,
  output logic [7:0]         segment,
  output logic [DIGITS-1:0]  AN
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W =
    (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam int IDX_W =
    (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = $clog2(REFRESH_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(SCORE_W - 1);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(REFRESH_DIV - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CONV = 1'b1;

  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  logic [0:0]         state;
  logic [SCORE_W-1:0] sr;
  logic [BCD_W-1:0]   bcd;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_nxt;
  logic [BCD_W-1:0]   disp;
  logic               ovf_acc;
  logic               ovf_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               last;
  logic               pend_vld;
  logic [SCORE_W-1:0] pend;

  logic [IDX_W-1:0]   idx;
  logic [DIV_W-1:0]   div;
  logic [3:0]         dig;
  logic               blank;
  logic [7:0]         seg_nxt;
  logic [DIGITS-1:0]  an_nxt;

  // Add-3 to every digit >= 5 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  assign bcd_nxt = {bcd_adj[BCD_W-2:0], sr[SCORE_W-1]};
  // Bit leaving the top digit means the value
  // does not fit in DIGITS decimal digits.
  assign ovf_nxt = ovf_acc | bcd_adj[BCD_W-1];
  assign last    = (cnt == CNT_LAST);
  assign busy    = (state == CONV);

  always_ff @(posedge clk_100mhz) begin
    if (!RSTN) begin
      state    <= IDLE;
      sr       <= '0;
      bcd      <= '0;
      ovf_acc  <= 1'b0;
      cnt      <= '0;
      pend_vld <= 1'b0;
      pend     <= '0;
      disp     <= '0;
      overflow <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (score_valid) begin
            state   <= CONV;
            sr      <= score;
            bcd     <= '0;
            ovf_acc <= 1'b0;
            cnt     <= '0;
          end
        end
        (state == CONV): begin
          sr      <= sr << 1;
          bcd     <= bcd_nxt;
          ovf_acc <= ovf_nxt;
          cnt     <= cnt + 1'b1;
          if (last) begin
            disp     <= bcd_nxt;
            overflow <= ovf_nxt;
            // Chain straight into the queued score so
            // busy shows no gap; a valid in this very
            // cycle is newer than the pending one.
            if (score_valid || pend_vld) begin
              sr       <= score_valid ? score : pend;
              bcd      <= '0;
              ovf_acc  <= 1'b0;
              cnt      <= '0;
              pend_vld <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else if (score_valid) begin
            pend     <= score;
            pend_vld <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dig = disp[4*idx +: 4];

`ifdef SCORE_SEG_SCAN_BLANK_EN
  // lz[i]: digit i and all digits above it are zero.
  logic [DIGITS-1:0] lz;

  always_comb begin
    lz = '0;
    lz[DIGITS-1] = (disp[BCD_W-1 -: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      lz[i] = lz[i+1] && (disp[4*i +: 4] == 4'd0);
    end
  end

  assign blank = (idx != '0) && lz[idx];
`else
  assign blank = 1'b0;
`endif

  function automatic logic [7:0] enc(
    input logic [3:0] d
  );
    case (d)
      4'd0:    enc = 8'hC0;
      4'd1:    enc = 8'hF9;
      4'd2:    enc = 8'hA4;
      4'd3:    enc = 8'hB0;
      4'd4:    enc = 8'h99;
      4'd5:    enc = 8'h92;
      4'd6:    enc = 8'h82;
      4'd7:    enc = 8'hF8;
      4'd8:    enc = 8'h80;
      4'd9:    enc = 8'h90;
      default: enc = SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    seg_nxt = enc(dig);
    if (overflow) begin
      seg_nxt = SEG_DASH;
    end else if (blank) begin
      seg_nxt = SEG_BLANK;
    end
  end

  assign an_nxt = ~(DIGITS'(1) << idx);

  always_ff @(posedge clk_100mhz) begin
    if (!RSTN) begin
      idx     <= '0;
      div     <= '0;
      segment <= SEG_BLANK;
      AN      <= '1;
    end else begin
      segment <= seg_nxt;
      AN      <= an_nxt;
      if (div == DIV_LAST) begin
        div <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_score_seg_scan.sv
// Scoreboard bench for score_seg_scan (REFRESH_DIV=4).
// Expected items are queued by cycle; a monitor pops and checks.
module tb_score_seg_scan;

  localparam int SW = 32;
  localparam int ND = 4;
  localparam int RD = 4;

  localparam int K_BUSY = 0;
  localparam int K_RAW  = 1;
  localparam int K_DONE = 2;

`ifdef SCORE_SEG_SCAN_BLANK_EN
  localparam logic [7:0] Z = 8'hFF;
`else
  localparam logic [7:0] Z = 8'hC0;
`endif

  logic          clk_100mhz = 1'b0;
  logic          RSTN;
  logic [SW-1:0] score;
  logic          score_valid;
  logic          busy;
  logic          overflow;
  logic [7:0]    segment;
  logic [ND-1:0] AN;

  score_seg_scan #(
    .SCORE_W(SW),
    .DIGITS(ND),
    .REFRESH_DIV(RD)
  ) dut (
    .clk_100mhz(clk_100mhz),
    .RSTN(RSTN),
    .score(score),
    .score_valid(score_valid),
    .busy(busy),
    .overflow(overflow),
    .segment(segment),
    .AN(AN)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int cyc = 0;
  always @(posedge clk_100mhz) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          cyc;
    int          kind;
    logic        busy;
    logic        ovf;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [31:0] segs;
  } item_t;

  item_t q[$];

  task automatic add(
    input int          c,
    input int          kind,
    input logic        b,
    input logic        o,
    input logic [7:0]  sg,
    input logic [3:0]  an,
    input logic [31:0] segs
  );
    item_t it;
    int    i;
    it.cyc  = c;
    it.kind = kind;
    it.busy = b;
    it.ovf  = o;
    it.seg  = sg;
    it.an   = an;
    it.segs = segs;
    i = 0;
    while (i < q.size() && q[i].cyc <= c) i++;
    q.insert(i, it);
  endtask

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  // Monitor
  logic        scan_on = 1'b0;
  int          scan_end;
  logic [31:0] scan_segs;

  initial begin
    item_t it;
    int    zc;
    int    hit;
    forever begin
      @(negedge clk_100mhz);
      if (scan_on) begin
        if (cyc > scan_end) begin
          scan_on = 1'b0;
        end else begin
          zc  = 0;
          hit = 0;
          for (int i = 0; i < ND; i++) begin
            if (AN[i] == 1'b0) begin
              zc++;
              hit = i;
            end
          end
          chk("scan_an_onehot", zc, 1);
          if (zc == 1) begin
            chk("scan_segment", segment,
                scan_segs[8*hit +: 8]);
          end
        end
      end
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        it = q.pop_front();
        if (it.cyc < cyc) begin
          tests++;
          fails++;
          $display("FAIL missed_check: item cycle %0d, now %0d",
                   it.cyc, cyc);
        end else begin
          chk("busy", busy, it.busy);
          if (it.kind != K_BUSY) chk("overflow", overflow, it.ovf);
          if (it.kind == K_RAW) begin
            chk("segment", segment, it.seg);
            chk("AN", AN, it.an);
          end
          if (it.kind == K_DONE) begin
            scan_on   = 1'b1;
            scan_end  = cyc + 16;
            scan_segs = it.segs;
          end
        end
      end
    end
  end

  task automatic issue(input logic [SW-1:0] s, output int n);
    @(negedge clk_100mhz);
    score       = s;
    score_valid = 1'b1;
    @(negedge clk_100mhz);
    score_valid = 1'b0;
    n = cyc;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk_100mhz);
  endtask

  // Stimulus
  initial begin
    int n;
    int n0;
    int n1;
    RSTN        = 1'b0;
    score       = '0;
    score_valid = 1'b0;

    // reset state, then scan starts on digit 0
    add(2, K_RAW, 1'b0, 1'b0, 8'hFF, 4'hF, 32'h0);
    add(3, K_RAW, 1'b0, 1'b0, 8'hC0, 4'hE, 32'h0);
    add(7, K_RAW, 1'b0, 1'b0, Z, 4'hD, 32'h0);
    repeat (2) @(negedge clk_100mhz);
    RSTN = 1'b1;
    wait_until(12);

    // basic 1234
    issue(1234, n);
    add(n + 1, K_BUSY, 1'b1, 1'b0, 8'h0, 4'h0, 32'h0);
    add(n + 31, K_BUSY, 1'b1, 1'b0, 8'h0, 4'h0, 32'h0);
    add(n + 32, K_DONE, 1'b0, 1'b0, 8'h0, 4'h0,
        {8'hF9, 8'hA4, 8'hB0, 8'h99});
    wait_until(n + 52);

    // overflow 10000
    issue(10000, n);
    add(n + 1, K_BUSY, 1'b1, 1'b0, 8'h0, 4'h0, 32'h0);
    add(n + 32, K_DONE, 1'b0, 1'b1, 8'h0, 4'h0, 32'hBFBFBFBF);
    wait_until(n + 52);

    // max 9999 clears overflow
    issue(9999, n);
    add(n + 32, K_DONE, 1'b0, 1'b0, 8'h0, 4'h0, 32'h90909090);
    wait_until(n + 52);

    // back-to-back 12, 34, 56: 34 dropped
    issue(12, n0);
    for (int c = n0 + 1; c < n0 + 64; c++) begin
      add(c, K_BUSY, 1'b1, 1'b0, 8'h0, 4'h0, 32'h0);
    end
    add(n0 + 32, K_DONE, 1'b1, 1'b0, 8'h0, 4'h0,
        {Z, Z, 8'hF9, 8'hA4});
    add(n0 + 64, K_DONE, 1'b0, 1'b0, 8'h0, 4'h0,
        {Z, Z, 8'h92, 8'h82});
    repeat (3) @(negedge clk_100mhz);
    issue(34, n1);
    repeat (3) @(negedge clk_100mhz);
    issue(56, n1);
    wait_until(n0 + 84);

    // leading zeros
    issue(7, n);
    add(n + 32, K_DONE, 1'b0, 1'b0, 8'h0, 4'h0,
        {Z, Z, Z, 8'hF8});
    wait_until(n + 52);

    // reset mid-conversion, valid during reset ignored
    issue(5678, n);
    add(n + 9, K_BUSY, 1'b1, 1'b0, 8'h0, 4'h0, 32'h0);
    add(n + 10, K_RAW, 1'b0, 1'b0, 8'hFF, 4'hF, 32'h0);
    add(n + 12, K_RAW, 1'b0, 1'b0, 8'hC0, 4'hE, 32'h0);
    add(n + 40, K_DONE, 1'b0, 1'b0, 8'h0, 4'h0,
        {Z, Z, Z, 8'hC0});
    wait_until(n + 9);
    RSTN = 1'b0;
    @(negedge clk_100mhz);
    score       = 9999;
    score_valid = 1'b1;
    @(negedge clk_100mhz);
    score_valid = 1'b0;
    RSTN        = 1'b1;
    wait_until(n + 70);

    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
